// File: rtl/idex_pipe_reg_if.sv
// ============================================================================
// idex_pipe_reg_if : ID/EX stage bundle (ID fields, EX fields, hazard, counters)
// Rev 1.0
// ============================================================================
`default_nettype none

interface idex_pipe_reg_if #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3,
  parameter int ALUOP_W    = 2,
  parameter int CNT_W      = 8
);
  logic                  stall;
  logic                  flush;
  logic                  clear_counters;
  logic                  id_valid;
  logic                  reg_dst, branch, mem_read, mem_to_reg;
  logic                  mem_write, alu_src, reg_write;
  logic [ALUOP_W-1:0]    alu_op;
  logic [DATA_W-1:0]     pc4, read_data1, read_data2, ext_imm;
  logic [REG_ADDR_W-1:0] rs, rt, rd;

  logic                  ex_valid;
  logic                  reg_dst_out, branch_out, mem_read_out, mem_to_reg_out;
  logic                  mem_write_out, alu_src_out, reg_write_out;
  logic [ALUOP_W-1:0]    alu_op_out;
  logic [DATA_W-1:0]     pc4_out, read_data1_out, read_data2_out, ext_imm_out;
  logic [REG_ADDR_W-1:0] rs_out, rt_out, rd_out;
  logic                  load_use_hazard;
  logic [CNT_W-1:0]      stall_count, flush_count;

  modport master (
    output stall, flush, clear_counters, id_valid,
    output reg_dst, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write,
    output alu_op, pc4, read_data1, read_data2, ext_imm, rs, rt, rd,
    input  ex_valid,
    input  reg_dst_out, branch_out, mem_read_out, mem_to_reg_out,
    input  mem_write_out, alu_src_out, reg_write_out,
    input  alu_op_out, pc4_out, read_data1_out, read_data2_out, ext_imm_out,
    input  rs_out, rt_out, rd_out, load_use_hazard, stall_count, flush_count
  );

  modport slave (
    input  stall, flush, clear_counters, id_valid,
    input  reg_dst, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write,
    input  alu_op, pc4, read_data1, read_data2, ext_imm, rs, rt, rd,
    output ex_valid,
    output reg_dst_out, branch_out, mem_read_out, mem_to_reg_out,
    output mem_write_out, alu_src_out, reg_write_out,
    output alu_op_out, pc4_out, read_data1_out, read_data2_out, ext_imm_out,
    output rs_out, rt_out, rd_out, load_use_hazard, stall_count, flush_count
  );
endinterface

`default_nettype wire

// File: rtl/idex_pipe_reg.sv
// ============================================================================
// idex_pipe_reg : falling-edge ID/EX register with stall/flush, hazard, counters
// Rev 1.0
// ============================================================================
`default_nettype none

module idex_pipe_reg #(
  parameter int DATA_W        = 16,
  parameter int REG_ADDR_W    = 3,
  parameter int ALUOP_W       = 2,
  parameter int CNT_W         = 8,
  parameter bit ZERO_REG_HARD = 1'b1
) (
  input  wire logic      clock,
  input  wire logic      reset_n,
  idex_pipe_reg_if.slave pipe
);
  // Control bit order {reg_dst, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write}
  localparam int               c_mem_read_bit = 4;
  localparam logic [CNT_W-1:0] c_cnt_max      = {CNT_W{1'b1}};

  logic                  r_ex_valid;
  logic [6:0]            r_ctrl;
  logic [ALUOP_W-1:0]    r_alu_op;
  logic [DATA_W-1:0]     r_pc4, r_rd1, r_rd2, r_imm;
  logic [REG_ADDR_W-1:0] r_rs, r_rt, r_rd;
  logic [CNT_W-1:0]      r_stall_cnt, r_flush_cnt;

  logic [6:0]            w_ctrl_in;
  logic [6:0]            w_ctrl_load;
  logic [ALUOP_W-1:0]    w_alu_op_load;
  logic                  w_rt_match;
  logic                  w_rt_usable;

  assign w_ctrl_in     = {pipe.reg_dst, pipe.branch, pipe.mem_read, pipe.mem_to_reg,
                          pipe.mem_write, pipe.alu_src, pipe.reg_write};
  assign w_ctrl_load   = pipe.id_valid ? w_ctrl_in   : 7'd0;
  assign w_alu_op_load = pipe.id_valid ? pipe.alu_op : {ALUOP_W{1'b0}};

  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n || pipe.flush) begin
      r_ex_valid <= 1'b0;
      r_ctrl     <= 7'd0;
      r_alu_op   <= {ALUOP_W{1'b0}};
      r_pc4      <= {DATA_W{1'b0}};
      r_rd1      <= {DATA_W{1'b0}};
      r_rd2      <= {DATA_W{1'b0}};
      r_imm      <= {DATA_W{1'b0}};
      r_rs       <= {REG_ADDR_W{1'b0}};
      r_rt       <= {REG_ADDR_W{1'b0}};
      r_rd       <= {REG_ADDR_W{1'b0}};
    end else if (!pipe.stall) begin
      r_ex_valid <= pipe.id_valid;
      r_ctrl     <= w_ctrl_load;
      r_alu_op   <= w_alu_op_load;
      r_pc4      <= pipe.pc4;
      r_rd1      <= pipe.read_data1;
      r_rd2      <= pipe.read_data2;
      r_imm      <= pipe.ext_imm;
      r_rs       <= pipe.rs;
      r_rt       <= pipe.rt;
      r_rd       <= pipe.rd;
    end
  end

  // Counters saturate; clear wins over any increment on the same edge.
  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n || pipe.clear_counters) begin
      r_stall_cnt <= {CNT_W{1'b0}};
      r_flush_cnt <= {CNT_W{1'b0}};
    end else begin
      if (pipe.stall && !pipe.flush && (r_stall_cnt != c_cnt_max))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (pipe.flush && (r_flush_cnt != c_cnt_max))
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign w_rt_match = (r_rt == pipe.rs) || (r_rt == pipe.rt);

  generate
    if (ZERO_REG_HARD) begin : g_zero_hard
      assign w_rt_usable = |r_rt;
    end else begin : g_zero_soft
      assign w_rt_usable = 1'b1;
    end
  endgenerate

  assign pipe.load_use_hazard = r_ex_valid & r_ctrl[c_mem_read_bit] & pipe.id_valid &
                                w_rt_match & w_rt_usable;

  assign pipe.ex_valid = r_ex_valid;
  assign {pipe.reg_dst_out, pipe.branch_out, pipe.mem_read_out, pipe.mem_to_reg_out,
          pipe.mem_write_out, pipe.alu_src_out, pipe.reg_write_out} = r_ctrl;
  assign pipe.alu_op_out     = r_alu_op;
  assign pipe.pc4_out        = r_pc4;
  assign pipe.read_data1_out = r_rd1;
  assign pipe.read_data2_out = r_rd2;
  assign pipe.ext_imm_out    = r_imm;
  assign pipe.rs_out         = r_rs;
  assign pipe.rt_out         = r_rt;
  assign pipe.rd_out         = r_rd;
  assign pipe.stall_count    = r_stall_cnt;
  assign pipe.flush_count    = r_flush_cnt;

endmodule

`default_nettype wire

// File: tb/tb_idex_pipe_reg.sv
// ============================================================================
// tb_idex_pipe_reg : directed vectors, expected values queued, monitor compares
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_idex_pipe_reg;
  // {valid, ctrl[6:0], alu_op, pc4, rd1, rd2, imm, rs, rt, rd}
  typedef struct packed {
    logic        valid;
    logic [6:0]  ctrl;
    logic [1:0]  alu;
    logic [15:0] pc4, d1, d2, imm;
    logic [2:0]  rs, rt, rd;
  } in_t;

  typedef struct packed {
    in_t        r;
    logic       haz;
    logic [7:0] sc, fc;
    logic [1:0] sc2, fc2;
  } exp_t;

  localparam in_t IN_A     = {1'b1, 7'b0000001, 2'b10, 16'h0012, 16'hBEEF, 16'h1234, 16'hFFF0, 3'd1, 3'd2, 3'd5};
  localparam in_t IN_A_INV = {1'b0, 7'b0000001, 2'b10, 16'h0012, 16'hBEEF, 16'h1234, 16'hFFF0, 3'd1, 3'd2, 3'd5};
  localparam in_t OUT_AINV = {1'b0, 7'b0000000, 2'b00, 16'h0012, 16'hBEEF, 16'h1234, 16'hFFF0, 3'd1, 3'd2, 3'd5};
  localparam in_t IN_B     = {1'b1, 7'b1010101, 2'b01, 16'h0034, 16'h5555, 16'hAAAA, 16'h0007, 3'd6, 3'd7, 3'd4};
  localparam in_t IN_C     = {1'b1, 7'b0010000, 2'b00, 16'h0100, 16'h0001, 16'h0002, 16'h0003, 3'd1, 3'd4, 3'd4};
  localparam in_t IN_D     = {1'b1, 7'b0000001, 2'b11, 16'h0200, 16'h1111, 16'h2222, 16'h3333, 3'd4, 3'd1, 3'd3};
  localparam in_t IN_F     = {1'b1, 7'b0000001, 2'b11, 16'h0200, 16'h1111, 16'h2222, 16'h3333, 3'd2, 3'd2, 3'd3};
  localparam in_t IN_G     = {1'b0, 7'b0000001, 2'b11, 16'h0200, 16'h1111, 16'h2222, 16'h3333, 3'd4, 3'd4, 3'd3};
  localparam in_t IN_E     = {1'b1, 7'b0010000, 2'b01, 16'h0300, 16'h0F0F, 16'hF0F0, 16'h00FF, 3'd0, 3'd0, 3'd0};
  localparam in_t ZR       = '0;

  logic clock;
  logic reset_n;

  idex_pipe_reg_if #(.DATA_W(16), .REG_ADDR_W(3), .ALUOP_W(2), .CNT_W(8)) if8 ();
  idex_pipe_reg_if #(.DATA_W(16), .REG_ADDR_W(3), .ALUOP_W(2), .CNT_W(2)) if2 ();

  idex_pipe_reg #(.DATA_W(16), .REG_ADDR_W(3), .ALUOP_W(2), .CNT_W(8), .ZERO_REG_HARD(1'b1)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .pipe    (if8.slave)
  );

  idex_pipe_reg #(.DATA_W(16), .REG_ADDR_W(3), .ALUOP_W(2), .CNT_W(2), .ZERO_REG_HARD(1'b1)) dut_small (
    .clock   (clock),
    .reset_n (reset_n),
    .pipe    (if2.slave)
  );

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic exp_t ex(input in_t r, input logic h, input logic [7:0] sc, input logic [7:0] fc,
                              input logic [1:0] sc2, input logic [1:0] fc2);
    ex = {r, h, sc, fc, sc2, fc2};
  endfunction

  task automatic apply(input in_t d);
    {if8.id_valid, if8.reg_dst, if8.branch, if8.mem_read, if8.mem_to_reg, if8.mem_write,
     if8.alu_src, if8.reg_write, if8.alu_op, if8.pc4, if8.read_data1, if8.read_data2,
     if8.ext_imm, if8.rs, if8.rt, if8.rd} = d;
  endtask

  // Drive one vector shortly after the rising edge; the DUT captures it on the falling edge.
  task automatic vec(input logic rn, input logic pulse, input logic st, input logic fl,
                     input logic clr, input in_t d, input exp_t e);
    @(posedge clock);
    #1;
    apply(d);
    if8.stall = st;  if8.flush = fl;  if8.clear_counters = clr;
    if2.stall = st;  if2.flush = fl;  if2.clear_counters = clr;
    reset_n = rn;
    q.push_back(e);
    if (pulse) begin
      reset_n = 1'b0;
      #2;
      reset_n = 1'b1;
    end
  endtask

  always @(posedge clock) begin
    exp_t e;
    exp_t a;
    if (q.size() > 0) begin
      e = q.pop_front();
      a.r = {if8.ex_valid, if8.reg_dst_out, if8.branch_out, if8.mem_read_out, if8.mem_to_reg_out,
             if8.mem_write_out, if8.alu_src_out, if8.reg_write_out, if8.alu_op_out, if8.pc4_out,
             if8.read_data1_out, if8.read_data2_out, if8.ext_imm_out, if8.rs_out, if8.rt_out,
             if8.rd_out};
      a.haz = if8.load_use_hazard;
      a.sc  = if8.stall_count;
      a.fc  = if8.flush_count;
      a.sc2 = if2.stall_count;
      a.fc2 = if2.flush_count;
      n_vec++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL vec%0d: got %h, expected %h", n_vec, a, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, expected finish before 200us");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    apply(ZR);
    if8.stall = 0; if8.flush = 0; if8.clear_counters = 0;
    if2.stall = 0; if2.flush = 0; if2.clear_counters = 0;
    {if2.id_valid, if2.reg_dst, if2.branch, if2.mem_read, if2.mem_to_reg, if2.mem_write,
     if2.alu_src, if2.reg_write, if2.alu_op, if2.pc4, if2.read_data1, if2.read_data2,
     if2.ext_imm, if2.rs, if2.rt, if2.rd} = ZR;
    repeat (2) @(posedge clock);

    //  rn pl st fl cl  inputs    expected regs  haz  sc     fc     sc2   fc2
    vec(0, 0, 1, 1, 0, IN_B,     ex(ZR,       0, 8'd0, 8'd0, 2'd0, 2'd0));
    vec(1, 0, 0, 0, 0, IN_A,     ex(IN_A,     0, 8'd0, 8'd0, 2'd0, 2'd0));
    vec(1, 0, 0, 0, 0, IN_A_INV, ex(OUT_AINV, 0, 8'd0, 8'd0, 2'd0, 2'd0));
    vec(1, 0, 0, 0, 0, IN_A,     ex(IN_A,     0, 8'd0, 8'd0, 2'd0, 2'd0));
    vec(1, 0, 1, 0, 0, IN_B,     ex(IN_A,     0, 8'd1, 8'd0, 2'd1, 2'd0));
    vec(1, 0, 1, 0, 0, IN_B,     ex(IN_A,     0, 8'd2, 8'd0, 2'd2, 2'd0));
    vec(1, 0, 1, 0, 0, IN_B,     ex(IN_A,     0, 8'd3, 8'd0, 2'd3, 2'd0));
    vec(1, 0, 0, 0, 0, IN_B,     ex(IN_B,     1, 8'd3, 8'd0, 2'd3, 2'd0));
    vec(1, 0, 1, 1, 0, IN_B,     ex(ZR,       0, 8'd3, 8'd1, 2'd3, 2'd1));
    vec(1, 0, 0, 0, 0, IN_C,     ex(IN_C,     1, 8'd3, 8'd1, 2'd3, 2'd1));
    vec(1, 0, 1, 0, 0, IN_D,     ex(IN_C,     1, 8'd4, 8'd1, 2'd3, 2'd1));
    vec(1, 0, 1, 0, 0, IN_F,     ex(IN_C,     0, 8'd5, 8'd1, 2'd3, 2'd1));
    vec(1, 0, 1, 0, 0, IN_G,     ex(IN_C,     0, 8'd6, 8'd1, 2'd3, 2'd1));
    vec(1, 0, 0, 0, 0, IN_E,     ex(IN_E,     0, 8'd6, 8'd1, 2'd3, 2'd1));
    // Reset pulsed between edges while stalled: state cleared, next edge is a normal stall.
    vec(1, 1, 1, 0, 0, IN_A,     ex(ZR,       0, 8'd1, 8'd0, 2'd1, 2'd0));
    vec(1, 0, 0, 0, 0, IN_A,     ex(IN_A,     0, 8'd1, 8'd0, 2'd1, 2'd0));
    vec(1, 0, 1, 0, 0, IN_B,     ex(IN_A,     0, 8'd2, 8'd0, 2'd2, 2'd0));
    vec(1, 0, 1, 0, 0, IN_B,     ex(IN_A,     0, 8'd3, 8'd0, 2'd3, 2'd0));
    vec(1, 0, 1, 0, 0, IN_B,     ex(IN_A,     0, 8'd4, 8'd0, 2'd3, 2'd0));
    vec(1, 0, 1, 0, 0, IN_B,     ex(IN_A,     0, 8'd5, 8'd0, 2'd3, 2'd0));
    vec(1, 0, 1, 0, 0, IN_B,     ex(IN_A,     0, 8'd6, 8'd0, 2'd3, 2'd0));
    vec(1, 0, 1, 0, 1, IN_B,     ex(IN_A,     0, 8'd0, 8'd0, 2'd0, 2'd0));
    vec(1, 0, 0, 1, 0, IN_B,     ex(ZR,       0, 8'd0, 8'd1, 2'd0, 2'd1));
    vec(1, 0, 0, 1, 1, IN_B,     ex(ZR,       0, 8'd0, 8'd0, 2'd0, 2'd0));
    vec(1, 0, 1, 0, 0, IN_B,     ex(ZR,       0, 8'd1, 8'd0, 2'd1, 2'd0));
    vec(1, 0, 0, 0, 0, IN_B,     ex(IN_B,     1, 8'd1, 8'd0, 2'd1, 2'd0));

    @(posedge clock);
    #1;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d vectors left unchecked, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/idex_pipe_reg.md
Name: idex_pipe_reg

Overview:
- Parametrised ID/EX pipeline register for the pipelined processor.
- Captures decoded control bits, operands, immediate, PC+4 and register specifiers from ID and presents them to EX.
- Adds capabilities the fixed-width stage register lacks:
  - hold (stall) and bubble insertion (flush);
  - a valid bit;
  - rs/rt forwarding specifiers;
  - load-use hazard detection;
  - saturating stall/flush event counters for performance debug.

Parameters:
- DATA_W, 16, width of PC+4, register-bank operands and sign-extended immediate.
- REG_ADDR_W, 3, width of rs/rt/rd register specifiers.
- ALUOP_W, 2, width of ALU operation code.
- CNT_W, 8, width of stall and flush event counters.
- ZERO_REG_HARD, 1, 1 = register 0 is hardwired zero and never raises a hazard.

Ports:
- clock  in  1  stage clock; all state updates on falling edge.
- reset_n  in  1  asynchronous, active-low reset.
- stall  in  1  hold all contents this edge.
- flush  in  1  load bubble this edge.
- clear_counters  in  1  synchronous clear of both counters.
- id_valid  in  1  ID slot holds a real instruction.
- reg_dst, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write  in  1 each  decoded control bits.
- alu_op  in  ALUOP_W  ALU operation code.
- pc4, read_data1, read_data2, ext_imm  in  DATA_W each  ID datapath values.
- rs, rt, rd  in  REG_ADDR_W each  register specifiers.
- ex_valid  out  1  EX slot holds a real instruction.
- reg_dst_out … reg_write_out  out  1 each  registered control bits.
- alu_op_out  out  ALUOP_W  registered ALU operation code.
- pc4_out, read_data1_out, read_data2_out, ext_imm_out  out  DATA_W each  registered datapath values.
- rs_out, rt_out, rd_out  out  REG_ADDR_W each  registered specifiers.
- load_use_hazard  out  1  combinational load-use hazard flag to the hazard unit.
- stall_count, flush_count  out  CNT_W each  saturating event counters.

Behaviour:
- Reset:
  - reset_n low asynchronously forces every registered output, including both counters, to 0.
  - Outputs stay 0 while reset_n is low.
  - Reset mid-stall or mid-flush discards all state; the first falling edge after release performs a normal update.
- Per falling edge, priority is flush > stall > load:
  - flush=1: every registered field and ex_valid become 0 (bubble), regardless of stall.
  - stall=1, flush=0: all fields hold their previous values.
  - Otherwise (load): all fields capture their inputs. ex_valid = id_valid.
  - Load with id_valid=0: the seven control bits and alu_op_out are forced to 0. Datapath and specifier fields still capture their inputs.
- Latency: one falling edge from input to output. No combinational path from inputs to registered outputs.
- load_use_hazard, purely combinational:
  - Asserts when ex_valid & mem_read_out & id_valid & (rt_out==rs | rt_out==rt).
  - When ZERO_REG_HARD=1, it is additionally gated by rt_out != 0.
  - The block does not self-stall; the external hazard unit drives stall.
- Counters, updated on the falling edge:
  - stall_count increments when stall=1 and flush=0.
  - flush_count increments when flush=1.
  - Each saturates at 2^CNT_W-1 and never wraps.
  - clear_counters=1 zeroes both counters on that edge and overrides any increment on the same edge.
  - Counters are independent of id_valid.
- All widths are exact. Specifier comparisons are REG_ADDR_W-bit equality. No sign or zero extension is performed inside the block.

Test Plan:
1. Reset: drive all inputs non-zero, pulse reset_n low between edges -> all outputs 0 immediately, with no clock edge needed.
2. Normal load: id_valid=1, pc4=0x0012, read_data1=0xBEEF, alu_op=2'b10, reg_write=1, rd=3'd5, one falling edge -> same values at outputs and ex_valid=1. Repeat with id_valid=0 -> controls 0, pc4_out=0x0012, ex_valid=0.
3. Stall: load the values from scenario 2, change inputs, hold stall=1 for 3 edges -> outputs unchanged and stall_count=3. Release stall -> new inputs appear after one edge.
4. Flush priority: stall=1 and flush=1 on the same edge -> all outputs 0, ex_valid=0, flush_count=1, stall_count unchanged.
5. Load-use hazard:
   - EX holds mem_read_out=1, rt_out=3'd4, ex_valid=1. ID presents id_valid=1, rs=3'd4 -> load_use_hazard=1.
   - With rs=rt=3'd2 -> 0.
   - With rt_out=0 and rs=0 (ZERO_REG_HARD=1) -> 0.
6. Saturation and clear with CNT_W=2: hold stall=1 for 5 edges -> stall_count=3. Then clear_counters=1 together with stall=1 -> stall_count=0.
